// File: rtl/spi_slave.sv
// Mode-0 SPI responder. SCLK/MOSI/SS_n are oversampled in the clk domain.
// Received words are strobed out, and transmit words come from a one-entry buffer.
module spi_slave #(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sclk,
    input  logic             mosi,
    input  logic             ss_n,
    output logic             miso,
    input  logic [width-1:0] tx_data,
    input  logic             tx_load,
    output logic             tx_ready,
    output logic [width-1:0] rx_data,
    output logic             rx_valid,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    localparam int cw = $clog2(width);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } state_t;

    state_t           state;
    logic [1:0]       sclk_sync, mosi_sync, ss_sync;
    logic             sclk_h, ss_h;
    logic [cw-1:0]    bit_cnt;
    logic [width-1:0] tx_buf, tx_shift, rx_shift;
    logic             reload, done;

    logic             sclk_rise, sclk_fall, ss_fall, ss_rise;
    logic             transfer;
    logic [width-1:0] buf_word;

    assign sclk_rise = sclk_sync[1] & ~sclk_h;
    assign sclk_fall = ~sclk_sync[1] & sclk_h;
    assign ss_fall   = ~ss_sync[1] & ss_h;
    assign ss_rise   = ss_sync[1] & ~ss_h;

    // A transfer empties the buffer; an empty buffer contributes all zeros.
    assign transfer  = (state == LOAD) ||
                       (state == SHIFT && !ss_rise && sclk_fall && reload);
    assign buf_word  = tx_ready ? '0 : tx_buf;
    assign dbg_state = state;

    // TX buffer: tx_load is accepted only in a cycle where tx_ready=1, and that
    // acceptance clears tx_ready. RX: rx_valid is a one-cycle strobe; rx_data
    // holds until the next completed word.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            sclk_sync <= '0;
            mosi_sync <= '0;
            ss_sync   <= '0;
            sclk_h    <= 1'b0;
            ss_h      <= 1'b0;
            bit_cnt   <= '0;
            tx_buf    <= '0;
            tx_shift  <= '0;
            rx_shift  <= '0;
            rx_data   <= '0;
            reload    <= 1'b0;
            done      <= 1'b0;
            rx_valid  <= 1'b0;
            tx_ready  <= 1'b1;
            miso      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[0], sclk};
            mosi_sync <= {mosi_sync[0], mosi};
            ss_sync   <= {ss_sync[0], ss_n};
            sclk_h    <= sclk_sync[1];
            ss_h      <= ss_sync[1];

            done     <= 1'b0;
            rx_valid <= done;
            busy     <= ~ss_sync[1] & ((state != IDLE) || ss_fall);
            miso     <= (state == SHIFT) ? tx_shift[width-1] : 1'b0;

            // The transfer sees the buffer as it was before a same-cycle load.
            if (tx_load && tx_ready) begin
                tx_buf   <= tx_data;
                tx_ready <= 1'b0;
            end else if (transfer) begin
                tx_ready <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (ss_fall) begin
                        state   <= LOAD;
                        bit_cnt <= '0;
                        reload  <= 1'b0;
                    end
                end
                LOAD: begin
                    tx_shift <= buf_word;
                    state    <= ss_rise ? IDLE : SHIFT;
                end
                SHIFT: begin
                    if (ss_rise) begin
                        state   <= IDLE;
                        bit_cnt <= '0;
                        reload  <= 1'b0;
                    end else begin
                        if (sclk_rise) begin
                            rx_shift <= {rx_shift[width-2:0], mosi_sync[1]};
                            if (bit_cnt == cw'(width - 1)) begin
                                rx_data <= {rx_shift[width-2:0], mosi_sync[1]};
                                done    <= 1'b1;
                                bit_cnt <= '0;
                                reload  <= 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                        if (sclk_fall) begin
                            if (reload) begin
                                tx_shift <= buf_word;
                                reload   <= 1'b0;
                            end else begin
                                tx_shift <= {tx_shift[width-2:0], 1'b0};
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
